// File: rtl/avalon_access_sequencer_pkg.sv
// Shared types and constants for the Avalon access sequencer.
// Holds the FSM state encoding and bus alignment helpers.
package avalon_access_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    FETCH,
    RELEASE,
    FAULT
  } state_t;

  localparam logic [3:0]  BE_ALL    = 4'hF;
  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

  function automatic logic [31:0] word_align(
    input logic [31:0] a
  );
    return a & WORD_MASK;
  endfunction

endpackage

// File: rtl/avalon_access_sequencer_if.sv
// Avalon-MM bus bundle between the sequencer and its slave.
// The master drives the request, the slave answers with wait/data.
interface avalon_access_sequencer_if;

  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        waitrequest;
  logic [31:0] readdata;

  modport master (
    output address,
    output read,
    output write,
    output writedata,
    output byteenable,
    input  waitrequest,
    input  readdata
  );

  modport slave (
    input  address,
    input  read,
    input  write,
    input  writedata,
    input  byteenable,
    output waitrequest,
    output readdata
  );

endinterface

// File: rtl/avalon_access_sequencer_bus_watchdog.sv
// Counts consecutive stalled bus cycles and flags a hung slave.
// expired fires on the TIMEOUT-th consecutive enabled cycle.
module bus_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign expired = enable && (count == LAST);

endmodule

// File: rtl/avalon_access_sequencer.sv
// Serialises a CPU data access and instruction fetch onto one
// Avalon-MM master; data always goes before the fetch.
module avalon_access_sequencer
  import avalon_access_sequencer_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_req,
  input  logic [31:0] instr_address,
  output logic [31:0] instr_readdata,
  input  logic        data_read,
  input  logic        data_write,
  input  logic [31:0] data_address,
  input  logic [31:0] data_writedata,
  input  logic [3:0]  data_byteenable,
  output logic [31:0] data_readdata,
  output logic        stall,
  output logic        bus_error,
  avalon_access_sequencer_if.master bus
);

  state_t state_q, state_d;

  logic        wr_q;
  logic        fetch_q;
  logic [31:0] daddr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic [31:0] iaddr_q;

  logic latch;
  logic cap_data;
  logic cap_instr;
  logic busy;
  logic wd_en;
  logic expired;
  logic data_req;
  logic misaligned;

  assign data_req   = data_read | data_write;
  assign misaligned = instr_req & (instr_address[1:0] != 2'b00);
  assign busy       = (state_q == DATA) | (state_q == FETCH);
  assign wd_en      = busy & bus.waitrequest;
  assign bus_error  = (state_q == FAULT);

  bus_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .enable (wd_en),
    .clear  (!wd_en),
    .expired(expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Requests are captured once so the bus stays stable under waitrequest.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q    <= 1'b0;
      fetch_q <= 1'b0;
      daddr_q <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      iaddr_q <= '0;
    end else if (latch) begin
      wr_q    <= data_write;
      fetch_q <= data_req ? instr_req : 1'b1;
      daddr_q <= data_address;
      wdata_q <= data_writedata;
      be_q    <= data_byteenable;
      iaddr_q <= instr_address;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_readdata <= '0;
      data_readdata  <= '0;
    end else begin
      if (cap_instr) begin
        instr_readdata <= bus.readdata;
      end
      if (cap_data) begin
        data_readdata <= bus.readdata;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    latch          = 1'b0;
    cap_data       = 1'b0;
    cap_instr      = 1'b0;
    stall          = 1'b1;
    bus.read       = 1'b0;
    bus.write      = 1'b0;
    bus.address    = '0;
    bus.writedata  = '0;
    bus.byteenable = '0;
    unique case (state_q)
      IDLE: begin
        if (data_req) begin
          latch   = 1'b1;
          state_d = misaligned ? FAULT : DATA;
        end else if (instr_req) begin
          latch   = 1'b1;
          state_d = misaligned ? FAULT : FETCH;
        end
      end
      DATA: begin
        bus.address    = word_align(daddr_q);
        bus.byteenable = be_q;
        bus.write      = wr_q;
        bus.read       = !wr_q;
        bus.writedata  = wr_q ? wdata_q : '0;
        if (expired) begin
          state_d = FAULT;
        end else if (!bus.waitrequest) begin
          cap_data = !wr_q;
          state_d  = fetch_q ? FETCH : RELEASE;
        end
      end
      FETCH: begin
        bus.address    = iaddr_q;
        bus.byteenable = BE_ALL;
        bus.read       = 1'b1;
        if (expired) begin
          state_d = FAULT;
        end else if (!bus.waitrequest) begin
          cap_instr = 1'b1;
          state_d   = RELEASE;
        end
      end
      RELEASE: begin
        stall   = 1'b0;
        state_d = IDLE;
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_avalon_access_sequencer.sv
// Randomised self-checking bench for avalon_access_sequencer.
// Expected beats and latencies come from a transaction-level model.
module tb_avalon_access_sequencer;

  localparam int TO = 8;

  typedef struct packed {
    logic [31:0] addr;
    logic        rd;
    logic        wr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        instr_req = 1'b0;
  logic [31:0] instr_address = '0;
  logic [31:0] instr_readdata;
  logic        data_read = 1'b0;
  logic        data_write = 1'b0;
  logic [31:0] data_address = '0;
  logic [31:0] data_writedata = '0;
  logic [3:0]  data_byteenable = '0;
  logic [31:0] data_readdata;
  logic        stall;
  logic        bus_error;

  int checks = 0;
  int failures = 0;

  beat_t obs_q[$];
  beat_t exp_q[$];

  logic        fix_rd = 1'b0;
  logic [31:0] fix_val = '0;

  avalon_access_sequencer_if bus();

  avalon_access_sequencer #(
    .TIMEOUT(TO)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .instr_req      (instr_req),
    .instr_address  (instr_address),
    .instr_readdata (instr_readdata),
    .data_read      (data_read),
    .data_write     (data_write),
    .data_address   (data_address),
    .data_writedata (data_writedata),
    .data_byteenable(data_byteenable),
    .data_readdata  (data_readdata),
    .stall          (stall),
    .bus_error      (bus_error),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: sim still running");
    $fatal(1);
  end

  // Issues one CPU request and plays the slave; records completed beats.
  task automatic drive_txn(
    input  logic        dr,
    input  logic        dw,
    input  logic        ir,
    input  logic [31:0] ia,
    input  logic [31:0] da,
    input  logic [31:0] wd,
    input  logic [3:0]  be,
    input  int          w0,
    input  int          w1,
    output int          rel,
    output int          act,
    output int          stab,
    output int          both
  );
    beat_t snap;
    beat_t cur;
    int    left;
    int    bidx;
    bit    inb;
    rel  = -1;
    act  = 0;
    stab = 0;
    both = 0;
    left = 0;
    bidx = 0;
    inb  = 1'b0;
    snap = '0;
    obs_q.delete();
    data_read       = dr;
    data_write      = dw;
    instr_req       = ir;
    instr_address   = ia;
    data_address    = da;
    data_writedata  = wd;
    data_byteenable = be;
    bus.waitrequest = 1'b0;
    for (int c = 2; c < 80; c++) begin
      @(negedge clk);
      data_read  = 1'b0;
      data_write = 1'b0;
      instr_req  = 1'b0;
      if (bus.read && bus.write) both++;
      if (!stall) begin
        rel = c;
        break;
      end
      cur       = '0;
      cur.addr  = bus.address;
      cur.rd    = bus.read;
      cur.wr    = bus.write;
      cur.be    = bus.byteenable;
      cur.wdata = bus.writedata;
      if (bus.read || bus.write) begin
        act++;
        if (!inb) begin
          inb  = 1'b1;
          left = (bidx == 0) ? w0 : w1;
          snap = cur;
        end else if (cur != snap) begin
          stab++;
        end
        if (left > 0) begin
          bus.waitrequest = 1'b1;
          left--;
        end else begin
          bus.waitrequest = 1'b0;
          bus.readdata    = fix_rd ? fix_val : $urandom;
          cur.rdata       = bus.readdata;
          obs_q.push_back(cur);
          inb = 1'b0;
          bidx++;
        end
      end else begin
        bus.waitrequest = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b0;
    bus.waitrequest = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.waitrequest = 1'b0;
    bus.readdata = '0;
    #13;
    checks++;
    if ({bus.read, bus.write, stall, bus_error} !== 4'b0010) begin
      failures++;
      $display("FAIL reset_ctrl: got rd/wr/stall/err=%b want 0010",
               {bus.read, bus.write, stall, bus_error});
    end
    checks++;
    if ({bus.address, bus.writedata, bus.byteenable,
         instr_readdata, data_readdata} !== '0) begin
      failures++;
      $display("FAIL reset_data: addr=%h wd=%h be=%h ird=%h drd=%h want 0",
               bus.address, bus.writedata, bus.byteenable,
               instr_readdata, data_readdata);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fetch_only();
    int rel, act, stab, both;
    fix_rd  = 1'b1;
    fix_val = 32'h2402_0005;
    drive_txn(0, 0, 1, 32'h1000, 0, 0, 0, 0, 0, rel, act, stab, both);
    fix_rd = 1'b0;
    checks++;
    if (rel !== 3) begin
      failures++;
      $display("FAIL fetch_latency: got %0d want 3", rel);
    end
    checks++;
    if (act !== 1) begin
      failures++;
      $display("FAIL fetch_read_cycles: got %0d want 1", act);
    end
    checks++;
    if (obs_q.size() != 1 || obs_q[0].addr !== 32'h1000 ||
        obs_q[0].rd !== 1'b1 || obs_q[0].be !== 4'hF) begin
      failures++;
      $display("FAIL fetch_beat: n=%0d got %p want addr 1000 rd be F",
               obs_q.size(), obs_q);
    end
    checks++;
    if (instr_readdata !== 32'h2402_0005) begin
      failures++;
      $display("FAIL fetch_data: got %h want 24020005", instr_readdata);
    end
  endtask

  task automatic test_store_fetch();
    int rel, act, stab, both;
    drive_txn(0, 1, 1, 32'h1000, 32'h2002, 32'hDEAD_BEEF, 4'b0011,
              0, 0, rel, act, stab, both);
    checks++;
    if (rel !== 4) begin
      failures++;
      $display("FAIL store_latency: got %0d want 4", rel);
    end
    checks++;
    if (obs_q.size() != 2) begin
      failures++;
      $display("FAIL store_beats: got %0d want 2", obs_q.size());
    end else begin
      checks++;
      if (obs_q[0].addr !== 32'h2000 || obs_q[0].wr !== 1'b1 ||
          obs_q[0].rd !== 1'b0 || obs_q[0].be !== 4'b0011 ||
          obs_q[0].wdata !== 32'hDEAD_BEEF) begin
        failures++;
        $display("FAIL store_beat0: got %p want wr 2000 be 3 deadbeef",
                 obs_q[0]);
      end
      checks++;
      if (obs_q[1].addr !== 32'h1000 || obs_q[1].rd !== 1'b1 ||
          obs_q[1].wr !== 1'b0) begin
        failures++;
        $display("FAIL store_beat1: got %p want rd 1000", obs_q[1]);
      end
      checks++;
      if (instr_readdata !== obs_q[1].rdata) begin
        failures++;
        $display("FAIL store_fetch_data: got %h want %h",
                 instr_readdata, obs_q[1].rdata);
      end
    end
  endtask

  task automatic test_load_wait();
    int rel, act, stab, both;
    drive_txn(1, 0, 0, 32'h0, 32'h3000, 32'h0, 4'hF, 5, 0,
              rel, act, stab, both);
    checks++;
    if (rel !== 8 || act !== 6) begin
      failures++;
      $display("FAIL load_wait_timing: rel=%0d act=%0d want 8 6", rel, act);
    end
    checks++;
    if (stab !== 0) begin
      failures++;
      $display("FAIL load_wait_stable: got %0d changes want 0", stab);
    end
    checks++;
    if (obs_q.size() != 1 || data_readdata !== obs_q[0].rdata) begin
      failures++;
      $display("FAIL load_wait_data: n=%0d got %h", obs_q.size(),
               data_readdata);
    end
    checks++;
    if (bus_error !== 1'b0) begin
      failures++;
      $display("FAIL load_wait_err: got %b want 0", bus_error);
    end
  endtask

  task automatic test_timeout();
    int rdcnt = 0;
    int lowcnt = 0;
    instr_req       = 1'b1;
    instr_address   = 32'h4000;
    bus.waitrequest = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      instr_req = 1'b0;
      if (bus.read) rdcnt++;
      if (!stall) lowcnt++;
    end
    checks++;
    if (rdcnt !== TO) begin
      failures++;
      $display("FAIL timeout_read_cycles: got %0d want %0d", rdcnt, TO);
    end
    checks++;
    if ({bus_error, stall, bus.read, bus.write} !== 4'b1100) begin
      failures++;
      $display("FAIL timeout_fault: err/stall/rd/wr=%b want 1100",
               {bus_error, stall, bus.read, bus.write});
    end
    checks++;
    if (lowcnt !== 0) begin
      failures++;
      $display("FAIL timeout_stall: got %0d low cycles want 0", lowcnt);
    end
    reset = 1'b0;
    bus.waitrequest = 1'b0;
    #1;
    checks++;
    if (bus_error !== 1'b0) begin
      failures++;
      $display("FAIL timeout_clear: got %b want 0", bus_error);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_misaligned();
    int act = 0;
    instr_req      = 1'b1;
    instr_address  = 32'h1002;
    data_write     = 1'b1;
    data_address   = 32'h6000;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      instr_req  = 1'b0;
      data_write = 1'b0;
      if (bus.read || bus.write) act++;
    end
    checks++;
    if ({bus_error, stall} !== 2'b11 || act !== 0) begin
      failures++;
      $display("FAIL misaligned: err/stall=%b acc=%0d want 11 0",
               {bus_error, stall}, act);
    end
    pulse_reset();
  endtask

  task automatic test_reset_mid();
    int rel, act, stab, both;
    data_write      = 1'b1;
    data_address    = 32'h5000;
    data_writedata  = 32'hA5A5_5A5A;
    data_byteenable = 4'hF;
    instr_req       = 1'b1;
    instr_address   = 32'h1000;
    bus.waitrequest = 1'b1;
    @(negedge clk);
    data_write = 1'b0;
    instr_req  = 1'b0;
    checks++;
    if (bus.write !== 1'b1) begin
      failures++;
      $display("FAIL mid_write_active: got %b want 1", bus.write);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({bus.read, bus.write, stall, bus_error} !== 4'b0010) begin
      failures++;
      $display("FAIL mid_reset_ctrl: rd/wr/stall/err=%b want 0010",
               {bus.read, bus.write, stall, bus_error});
    end
    checks++;
    if ({bus.address, bus.writedata, bus.byteenable,
         instr_readdata, data_readdata} !== '0) begin
      failures++;
      $display("FAIL mid_reset_data: addr=%h wd=%h be=%h ird=%h drd=%h",
               bus.address, bus.writedata, bus.byteenable,
               instr_readdata, data_readdata);
    end
    @(negedge clk);
    reset = 1'b1;
    fix_rd  = 1'b1;
    fix_val = 32'h0000_0013;
    drive_txn(0, 0, 1, 32'h1000, 0, 0, 0, 0, 0, rel, act, stab, both);
    fix_rd = 1'b0;
    checks++;
    if (rel !== 3 || instr_readdata !== 32'h13 || bus_error !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_refetch: rel=%0d ird=%h err=%b want 3 13 0",
               rel, instr_readdata, bus_error);
    end
  endtask

  task automatic test_random();
    int rel, act, stab, both;
    int exp_rel;
    int w[2];
    logic dr, dw, ir;
    logic [31:0] ia, da, wd;
    logic [3:0]  be;
    logic [31:0] exp_ird;
    logic [31:0] exp_drd;
    beat_t b;
    pulse_reset();
    exp_ird = '0;
    exp_drd = '0;
    for (int t = 0; t < 40; t++) begin
      dr   = 1'($urandom_range(0, 1));
      dw   = 1'($urandom_range(0, 1));
      ir   = 1'($urandom_range(0, 1));
      if (!dr && !dw) ir = 1'b1;
      ia   = $urandom & 32'hFFFF_FFFC;
      da   = $urandom;
      wd   = $urandom;
      be   = 4'($urandom_range(0, 15));
      w[0] = $urandom_range(0, 3);
      w[1] = $urandom_range(0, 3);
      exp_q.delete();
      if (dr || dw) begin
        b       = '0;
        b.addr  = da & 32'hFFFF_FFFC;
        b.wr    = dw;
        b.rd    = !dw;
        b.be    = be;
        b.wdata = wd;
        exp_q.push_back(b);
      end
      if (ir) begin
        b      = '0;
        b.addr = ia;
        b.rd   = 1'b1;
        b.be   = 4'hF;
        exp_q.push_back(b);
      end
      exp_rel = 2;
      foreach (exp_q[i]) exp_rel += 1 + w[i];
      drive_txn(dr, dw, ir, ia, da, wd, be, w[0], w[1],
                rel, act, stab, both);
      checks++;
      if (rel !== exp_rel) begin
        failures++;
        $display("FAIL rnd_latency t=%0d: got %0d want %0d", t, rel, exp_rel);
      end
      checks++;
      if (obs_q.size() != exp_q.size()) begin
        failures++;
        $display("FAIL rnd_beats t=%0d: got %0d want %0d", t,
                 obs_q.size(), exp_q.size());
      end else begin
        foreach (exp_q[i]) begin
          checks++;
          if (obs_q[i].addr !== exp_q[i].addr ||
              obs_q[i].rd !== exp_q[i].rd ||
              obs_q[i].wr !== exp_q[i].wr ||
              obs_q[i].be !== exp_q[i].be ||
              (exp_q[i].wr && obs_q[i].wdata !== exp_q[i].wdata)) begin
            failures++;
            $display("FAIL rnd_beat t=%0d i=%0d: got %p want %p", t, i,
                     obs_q[i], exp_q[i]);
          end
        end
        if (ir) exp_ird = obs_q[obs_q.size() - 1].rdata;
        if (dr && !dw) exp_drd = obs_q[0].rdata;
      end
      checks++;
      if (instr_readdata !== exp_ird || data_readdata !== exp_drd) begin
        failures++;
        $display("FAIL rnd_readdata t=%0d: ird=%h drd=%h want %h %h", t,
                 instr_readdata, data_readdata, exp_ird, exp_drd);
      end
      checks++;
      if (stab !== 0 || both !== 0 || bus_error !== 1'b0) begin
        failures++;
        $display("FAIL rnd_protocol t=%0d: unstable=%0d both=%0d err=%b",
                 t, stab, both, bus_error);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fetch_only();
    test_store_fetch();
    test_load_wait();
    test_timeout();
    test_misaligned();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/avalon_access_sequencer.md
AVALON_ACCESS_SEQUENCER -- requirements
Module: avalon_access_sequencer

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 1024, meaning the number of consecutive waitrequest-high cycles that is declared a bus failure.
REQ-002 clk  in  1  single system clock; all state changes on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 instr_req  in  1  CPU requests an instruction fetch for this CPU cycle.
REQ-005 instr_address  in  32  fetch address from CPU.
REQ-006 instr_readdata  out  32  registered fetched instruction.
REQ-007 data_read / data_write  in  1 each  CPU data access request.
REQ-008 data_address  in  32;  data_writedata  in  32;  data_byteenable  in  4  CPU data access fields.
REQ-009 data_readdata  out  32  registered load data.
REQ-010 stall  out  1  high = CPU SHALL NOT advance this cycle.
REQ-011 bus_error  out  1  sticky fault flag.
REQ-012 address out 32; read out 1; write out 1; writedata out 32; byteenable out 4; waitrequest in 1; readdata in 32  Avalon-MM master port.

Function
REQ-013 FSM states: IDLE, DATA, FETCH, RELEASE, FAULT.
REQ-014 IDLE: if data_write or data_read, latch data_address/writedata/byteenable/direction, latch instr_address, go DATA; else if instr_req, latch instr_address, go FETCH; else stay.
REQ-015 DATA: drive latched access (address = {addr[31:2],2'b00}); on cycle with waitrequest=0, capture readdata into data_readdata if read, then go FETCH if instr_req was latched, else RELEASE.
REQ-016 FETCH: read=1, byteenable=4'hF, address=latched instr_address; on waitrequest=0 capture readdata into instr_readdata, go RELEASE.
REQ-017 RELEASE: read=write=0, stall=0 for exactly one cycle, then IDLE.
REQ-018 stall SHALL be 1 in every state except RELEASE.
REQ-019 read and write SHALL never both be 1; both 0 in IDLE, RELEASE, FAULT.
REQ-020 address, writedata, byteenable, read, write SHALL remain stable while waitrequest=1.
REQ-021 data_read and data_write both high: treat as write only; data_readdata unchanged.
REQ-022 Write data access SHALL always complete before the fetch in the same CPU cycle.
REQ-023 Latency with waitrequest=0 throughout: fetch-only = 3 cycles IDLE->FETCH->RELEASE; load/store + fetch = 4 cycles.
REQ-024 Watchdog counts consecutive waitrequest=1 cycles in DATA/FETCH, clears on each completed beat; reaching TIMEOUT SHALL drop read/write, set bus_error, enter FAULT.
REQ-025 instr_address[1:0] != 0 at latch SHALL set bus_error and enter FAULT without bus access.
REQ-026 FAULT is terminal: stall=1, bus_error=1 until reset.
REQ-027 Misaligned data_address SHALL be word-aligned on the bus; byteenable passed unchanged.

Reset
REQ-028 Assertion (reset=0) SHALL immediately force state IDLE, read=0, write=0, bus_error=0, watchdog=0, stall=1, address/writedata/byteenable/instr_readdata/data_readdata=0, including mid-transaction.
REQ-029 After deassertion, the first request SHALL be sampled on the first rising edge with reset=1.

Structure
REQ-030 Shared package SHALL hold the state enum, BE_ALL=4'hF, and the word-align helper constant.
REQ-031 One sub-module bus_watchdog (counter, clear, enable, TIMEOUT parameter, expired output) SHALL implement REQ-024.

Verification
REQ-032 Fetch only, instr_address=0x1000, readdata=0x24020005, waitrequest=0 -> read high 1 cycle at 0x1000, stall low on cycle 3, instr_readdata=0x24020005.
REQ-033 Store 0xDEADBEEF to 0x2002, be=4'b0011, instr_req=1 -> write at 0x2000 be 0011, then read 0x1000, stall low on cycle 4.
REQ-034 Load with waitrequest high 5 cycles -> address/read stable all 5 cycles, data_readdata captured on 6th, no bus_error.
REQ-035 TIMEOUT=8, waitrequest stuck high -> read drops, bus_error=1 after 8 cycles, stall stays 1 until reset.
REQ-036 Reset pulsed mid-DATA with write=1 -> write=0 same cycle, all outputs zero, clean fetch afterwards.
